encoder_4x2_seq: RTL and testbench
==================================

# encoder_4x2_seq

Sequential 4-to-2 encoder that performs the inverse of the 2x4 decoder. It maps a 4-bit decoded line vector D[0:3] back to the 2-bit code {A,B}. A loaded vector may have several lines set; the block drains them one code per accepted transfer, lowest index first, through a valid/ready handshake. It sits on the receive side of a decoder link and turns observed select lines into a stream of binary codes.

## Interface
- No parameters; widths are fixed at 4 lines and a 2-bit code.
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  synchronous, active-low reset; sampled on rising edge of clk.
- enable  in  1  block enable; 0 freezes emission and blocks loads.
- load  in  1  capture strobe for D; sampled only in IDLE.
- D  in  [0:3]  decoded line vector; D[i] set means code i, with i = {A,B} and A as the MSB.
- ready  in  1  downstream accepts the current code.
- A  out  1  code MSB.
- B  out  1  code LSB.
- valid  out  1  {A,B} holds a code.
- busy  out  1  state is EMIT.
- done  out  1  one-cycle pulse after the last code of a vector is accepted.
- zero  out  1  one-cycle pulse when a load captures D = 0000.

## Operation
- States: IDLE and EMIT. A 4-bit pending register, pend, holds the lines not yet emitted.
- Reset (rst_n = 0 at an edge) sets:
  - state = IDLE, pend = 0000.
  - A = 0, B = 0, valid = 0, busy = 0, done = 0, zero = 0.
  - Reset overrides every other input in the same cycle.
- IDLE:
  - load = 1, enable = 1, D ≠ 0000: pend <= D, go to EMIT.
  - load = 1, enable = 1, D = 0000: zero = 1 for the next cycle, stay in IDLE.
  - load = 1, enable = 0: ignored.
- EMIT:
  - {A,B} = index of the lowest set bit of pend (D[0] gives 00, D[1] gives 01, D[2] gives 10, D[3] gives 11).
  - valid = enable.
  - Transfer occurs when valid = 1 and ready = 1 at an edge; that bit is then cleared in pend.
  - If that transfer empties pend: go to IDLE and pulse done for the next cycle.
- Backpressure: while ready = 0, {A,B} and pend hold steady and valid stays 1.
- enable = 0 in EMIT: valid = 0, pend and state hold, no transfer. Emission resumes with the same code when enable returns to 1.
- load in EMIT is ignored. D is sampled only on the capture edge and never again during EMIT.
- A, B and valid are decoded only from state and pend registers, so they never have a combinational path from D, load or ready.
- In IDLE: A = 0, B = 0, valid = 0.
- busy = 1 exactly while state = EMIT.

## Timing
- Capture at edge k gives valid = 1 and the first code during cycle k+1. A load is therefore never accepted in the cycle right after capture.
- With ready held at 1, a vector with n lines set gives n consecutive valid cycles (k+1 .. k+n).
- done is high during cycle k+n+1. busy falls in the same cycle.
- The earliest next capture is at edge k+n+1. That is back-to-back with done: a load in the done cycle is accepted.
- zero is high exactly one cycle, the cycle after the capture edge.
- valid drops in the same cycle enable falls (combinational from enable and registered state).
- Reset mid-EMIT discards pend. valid = 0 in the cycle after the reset edge, and no done pulse is produced.

## Test plan
- Reset: hold rst_n = 0 for 2 edges with load = 1 and D = 1111. Required: all outputs 0, state IDLE, and nothing captured.
- Single line: enable = 1, ready = 1, load with D = 0010. Required: one cycle of valid with {A,B} = 10, then done for 1 cycle, then IDLE.
- Multi-line drain: load D = 1011 with ready = 1. Required: {A,B} = 00, 10, 11 on three consecutive valid cycles, then done, then busy = 0.
- Backpressure and freeze:
  - Load D = 0101 and hold ready = 0 for 3 cycles. Required: {A,B} = 01, valid = 1, stable.
  - Then drop enable for 2 cycles. Required: valid = 0.
  - Then restore enable with ready = 1. Required: codes 01, 11, then done.
- Zero and ignored loads:
  - load with D = 0000. Required: zero pulse only, busy stays 0.
  - load with enable = 0. Required: no capture.
  - load = 1 with D = 1111 during EMIT. Required: no change to the codes being emitted.
- Reset mid-operation: load D = 1111, accept one code, then assert rst_n = 0 for one edge. Required: valid = 0 and busy = 0 next cycle, no done pulse, and a fresh load works normally.

Source files
------------

// File: rtl/encoder_4x2_seq_if.sv
// Handshake bundle between a line-vector source and the sequential 4-to-2 encoder.
// The master drives lines, load strobe and ready; the slave returns codes and status.
interface encoder_4x2_seq_if;
  logic       enable;
  logic       load;
  logic [0:3] D;
  logic       ready;
  logic       A;
  logic       B;
  logic       valid;
  logic       busy;
  logic       done;
  logic       zero;

  modport master (
    output enable, load, D, ready,
    input  A, B, valid, busy, done, zero
  );

  modport slave (
    input  enable, load, D, ready,
    output A, B, valid, busy, done, zero
  );
endinterface

// File: rtl/encoder_4x2_seq.sv
// Sequential 4-to-2 encoder: captures a decoded line vector and drains it as a
// stream of 2-bit codes, lowest line first, over a valid/ready handshake.
module encoder_4x2_seq (
  input  logic              clk,
  input  logic              rst_n,
  encoder_4x2_seq_if.slave  bus
);

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_e;

  state_e     state_q;
  logic [0:3] pend_q;
  logic [0:3] pend_d;
  logic       done_q;
  logic       zero_q;
  logic [1:0] code;
  logic       emit_valid;
  logic       xfer;

  // NOTE: every variable gets a default before the if-chain so no latch is inferred.
  always_comb begin
    code = 2'd0;
    if (pend_q[0])      code = 2'd0;
    else if (pend_q[1]) code = 2'd1;
    else if (pend_q[2]) code = 2'd2;
    else if (pend_q[3]) code = 2'd3;
  end

  // Pending set after the current code is accepted.
  always_comb begin
    pend_d       = pend_q;
    pend_d[code] = 1'b0;
  end

  assign emit_valid = (state_q == EMIT) && bus.enable;
  assign xfer       = emit_valid && bus.ready;

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pend_q  <= '0;
      done_q  <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      zero_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.load && bus.enable) begin
            if (bus.D != '0) begin
              pend_q  <= bus.D;
              state_q <= EMIT;
            end else begin
              zero_q <= 1'b1;
            end
          end
        end
        EMIT: begin
          if (xfer) begin
            pend_q <= pend_d;
            if (pend_d == '0) begin
              state_q <= IDLE;
              done_q  <= 1'b1;
            end
          end
        end
      endcase
    end
  end

  // Code and valid depend only on registered state plus enable, never on D/load/ready.
  assign bus.A     = (state_q == EMIT) ? code[1] : 1'b0;
  assign bus.B     = (state_q == EMIT) ? code[0] : 1'b0;
  assign bus.valid = emit_valid;
  assign bus.busy  = (state_q == EMIT);
  assign bus.done  = done_q;
  assign bus.zero  = zero_q;

endmodule

// File: tb/tb_encoder_4x2_seq.sv
// Self-checking bench for encoder_4x2_seq: a scoreboard queue holds the codes each
// load should yield, and a negedge monitor pops and compares them on every transfer.
module tb_encoder_4x2_seq;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  encoder_4x2_seq_if bus ();

  encoder_4x2_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int         n_tests  = 0;
  int         n_fail   = 0;
  logic [1:0] sb[$];
  logic       exp_done = 1'b0;
  logic       mon_en   = 1'b0;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive a one-cycle load; expected codes are queued only when a capture will happen.
  task automatic load_vec(input logic [0:3] d);
    bus.D    = d;
    bus.load = 1'b1;
    if (bus.enable && d != 4'b0000 && !bus.busy) begin
      for (int i = 0; i < 4; i++)
        if (d[i]) sb.push_back(2'(i));
    end
    tick();
    bus.load = 1'b0;
    bus.D    = 4'b0000;
  endtask

  task automatic check_code(input string tag, input logic [1:0] exp);
    check({tag, "_valid"}, 8'(bus.valid), 8'd1);
    check({tag, "_code"}, 8'({bus.A, bus.B}), 8'(exp));
  endtask

  // Transfer monitor: samples mid-cycle, when inputs and outputs are settled.
  always @(negedge clk) begin : monitor
    logic [1:0] e;
    if (mon_en) begin
      check("done_pulse", 8'(bus.done), 8'(exp_done));
      exp_done = 1'b0;
      if (rst_n && bus.valid && bus.ready) begin
        if (sb.size() == 0) begin
          check("unexpected_xfer", 8'(bus.valid), 8'd0);
        end else begin
          e = sb.pop_front();
          check("sb_code", 8'({bus.A, bus.B}), 8'(e));
          if (sb.size() == 0) exp_done = 1'b1;
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset held for two edges with a live load of 1111.
    bus.enable = 1'b1;
    bus.load   = 1'b1;
    bus.D      = 4'b1111;
    bus.ready  = 1'b1;
    rst_n      = 1'b0;
    tick();
    tick();
    check("rst_A",     8'(bus.A),     8'd0);
    check("rst_B",     8'(bus.B),     8'd0);
    check("rst_valid", 8'(bus.valid), 8'd0);
    check("rst_busy",  8'(bus.busy),  8'd0);
    check("rst_done",  8'(bus.done),  8'd0);
    check("rst_zero",  8'(bus.zero),  8'd0);
    rst_n    = 1'b1;
    bus.load = 1'b0;
    bus.D    = 4'b0000;
    mon_en   = 1'b1;
    tick();
    check("rst_nocap_busy",  8'(bus.busy),  8'd0);
    check("rst_nocap_valid", 8'(bus.valid), 8'd0);

    // Single line, then a back-to-back load in the done cycle.
    load_vec(4'b0010);
    check("single_busy", 8'(bus.busy), 8'd1);
    check_code("single", 2'b10);
    tick();
    check("single_done",  8'(bus.done),  8'd1);
    check("single_idle",  8'(bus.busy),  8'd0);
    check("single_valid", 8'(bus.valid), 8'd0);
    load_vec(4'b0001);
    check_code("b2b", 2'b11);
    tick();
    check("b2b_done", 8'(bus.done), 8'd1);
    tick();

    // Multi-line drain with ready held high.
    load_vec(4'b1011);
    for (int i = 0; i < 3; i++) begin
      check("multi_valid", 8'(bus.valid), 8'd1);
      tick();
    end
    check("multi_done", 8'(bus.done), 8'd1);
    check("multi_idle", 8'(bus.busy), 8'd0);
    tick();

    // Backpressure, then freeze via enable, then resume.
    bus.ready = 1'b0;
    load_vec(4'b0101);
    for (int i = 0; i < 3; i++) begin
      check_code("bp_hold", 2'b01);
      tick();
    end
    bus.enable = 1'b0;
    bus.ready  = 1'b1;
    #1;
    for (int i = 0; i < 2; i++) begin
      check("frz_valid", 8'(bus.valid), 8'd0);
      check("frz_busy",  8'(bus.busy),  8'd1);
      tick();
    end
    bus.enable = 1'b1;
    #1;
    check_code("resume0", 2'b01);
    tick();
    check_code("resume1", 2'b11);
    tick();
    check("resume_done", 8'(bus.done), 8'd1);
    tick();

    // Zero vector: only a zero pulse.
    load_vec(4'b0000);
    check("zero_pulse", 8'(bus.zero), 8'd1);
    check("zero_busy",  8'(bus.busy), 8'd0);
    tick();
    check("zero_once",  8'(bus.zero), 8'd0);

    // Load with enable low is ignored.
    bus.enable = 1'b0;
    load_vec(4'b1111);
    check("dis_busy", 8'(bus.busy), 8'd0);
    check("dis_zero", 8'(bus.zero), 8'd0);
    bus.enable = 1'b1;
    tick();

    // Load during EMIT is ignored.
    load_vec(4'b1001);
    bus.load = 1'b1;
    bus.D    = 4'b1111;
    check_code("emitld0", 2'b00);
    tick();
    check_code("emitld1", 2'b11);
    tick();
    bus.load = 1'b0;
    bus.D    = 4'b0000;
    check("emitld_done", 8'(bus.done), 8'd1);
    tick();
    check("emitld_idle", 8'(bus.busy), 8'd0);

    // Reset mid-EMIT discards the remaining lines and suppresses done.
    load_vec(4'b1111);
    check_code("mid0", 2'b00);
    tick();
    check_code("mid1", 2'b01);
    rst_n = 1'b0;
    sb.delete();
    tick();
    rst_n = 1'b1;
    check("midrst_valid", 8'(bus.valid), 8'd0);
    check("midrst_busy",  8'(bus.busy),  8'd0);
    check("midrst_done",  8'(bus.done),  8'd0);
    tick();
    check("midrst_nodone", 8'(bus.done), 8'd0);
    load_vec(4'b0010);
    check_code("post_rst", 2'b10);
    tick();
    check("post_rst_done", 8'(bus.done), 8'd1);
    tick();
    tick();

    check("sb_empty", 8'(sb.size()), 8'd0);
    mon_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
